// File: rtl/sensor_link.sv
// sensor_link: fans one command word per channel out to a sensor over a
// divided serial clock, MSB first, and collects the sensor's return stream
// into bytes with a one-deep read buffer and a sticky overflow flag.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a command handshake; cmd_out held at 0
// ALIGN  | command latched, waiting for the next sensor-clock fall
// SHIFT  | presenting bits on falls, capturing data_in on rises

module sensor_link #(
  parameter int CLK_DIV   = 20,
  parameter int NCH       = 8,
  parameter int WORD_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gate_mode,
  input  logic [NCH*WORD_BITS-1:0] cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [NCH-1:0]           cmd_out,
  output logic                     sclk_out,
  input  logic                     data_in,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic                     busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WORD_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIV_W-1:0]     div_cnt;
  logic                 phase;
  logic                 rise_tick;
  logic                 fall_tick;

  logic [WORD_BITS-1:0] sr [NCH];
  logic [BIT_W-1:0]     bit_cnt;

  logic [6:0]           cap_sr;
  logic [2:0]           cap_cnt;
  logic                 byte_done;
  logic [7:0]           new_byte;
  logic                 drop_byte;

  logic                 ready_en;

  logic                 load_sr;
  logic                 drive_bit;
  logic                 drive_zero;
  logic                 load_cnt;
  logic                 dec_cnt;
  logic                 cap_en;
  logic                 cap_clr;

  // Free-running divider; never restarted by the FSM so sclk_out stays periodic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign phase     = (div_cnt < DIV_HALF);
  assign rise_tick = (div_cnt == '0);
  assign fall_tick = (div_cnt == DIV_HALF);

  // Registered sensor clock; rises on the same edge that captures data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_out <= 1'b0;
    end else if (gate_mode) begin
      sclk_out <= phase && (state_q == ST_SHIFT);
    end else begin
      sclk_out <= phase;
    end
  end

  // Holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign cmd_ready = ready_en && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d    = state_q;
    load_sr    = 1'b0;
    drive_bit  = 1'b0;
    drive_zero = 1'b0;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    cap_en     = 1'b0;
    cap_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load_sr = 1'b1;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        cap_clr = 1'b1;
        if (fall_tick) begin
          drive_bit = 1'b1;
          load_cnt  = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cap_en = rise_tick;
        if (fall_tick) begin
          if (bit_cnt == '0) begin
            drive_zero = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            drive_bit = 1'b1;
            dec_cnt   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-channel shift registers and serial outputs; bits change only on falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        sr[k] <= '0;
      end
      cmd_out <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load_sr) begin
          sr[k] <= cmd_data[k*WORD_BITS +: WORD_BITS];
        end else if (drive_bit) begin
          sr[k] <= {sr[k][WORD_BITS-2:0], 1'b0};
        end
        if (drive_bit) begin
          cmd_out[k] <= sr[k][WORD_BITS-1];
        end else if (drive_zero) begin
          cmd_out[k] <= 1'b0;
        end
      end
    end
  end

  // Remaining-bit counter; zero on a fall means the last bit has been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (load_cnt) begin
      bit_cnt <= BIT_LAST;
    end else if (dec_cnt) begin
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  // Return-data capture; byte alignment restarts with every command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sr  <= '0;
      cap_cnt <= '0;
    end else if (cap_clr) begin
      cap_cnt <= '0;
    end else if (cap_en) begin
      cap_sr  <= {cap_sr[5:0], data_in};
      cap_cnt <= cap_cnt + 3'd1;
    end
  end

  assign byte_done = cap_en && (cap_cnt == 3'd7);
  assign new_byte  = {cap_sr, data_in};
  assign drop_byte = byte_done && rd_valid && !rd_ready;

  // One-deep read buffer; a byte that finds it full and unread is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else if (byte_done) begin
      if (!rd_valid || rd_ready) begin
        rd_data  <= new_byte;
        rd_valid <= 1'b1;
      end
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop_byte) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_link.sv
// Directed bench for sensor_link: an 8-bit-word instance and a 16-bit-word
// instance share stimulus; use16 selects which one a test drives and observes.

module tb_sensor_link;

  localparam int CLK_DIV = 4;
  localparam int HALF    = CLK_DIV / 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gate_mode;
  logic        cmd_valid;
  logic        data_in;
  logic        rd_ready;
  logic        clr_ovf;
  logic        use16;
  logic [31:0] cmd_word;

  int n_chk = 0;
  int n_err = 0;

  wire       v8   = cmd_valid & ~use16;
  wire       v16  = cmd_valid & use16;
  wire       rr8  = rd_ready & ~use16;
  wire       rr16 = rd_ready & use16;
  wire       co8  = clr_ovf & ~use16;
  wire       co16 = clr_ovf & use16;

  logic       ready8, sclk8, rdv8, ovf8, busy8;
  logic [1:0] out8;
  logic [7:0] rdd8;
  logic       ready16, sclk16, rdv16, ovf16, busy16;
  logic [1:0] out16;
  logic [7:0] rdd16;

  wire       s_ready    = use16 ? ready16 : ready8;
  wire       s_sclk     = use16 ? sclk16  : sclk8;
  wire       s_busy     = use16 ? busy16  : busy8;
  wire       s_rd_valid = use16 ? rdv16   : rdv8;
  wire       s_ovf      = use16 ? ovf16   : ovf8;
  wire [1:0] s_cmd_out  = use16 ? out16   : out8;
  wire [7:0] s_rd_data  = use16 ? rdd16   : rdd8;

  sensor_link #(.CLK_DIV(CLK_DIV), .NCH(2), .WORD_BITS(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .gate_mode (gate_mode),
    .cmd_data  (cmd_word[15:0]),
    .cmd_valid (v8),
    .cmd_ready (ready8),
    .cmd_out   (out8),
    .sclk_out  (sclk8),
    .data_in   (data_in),
    .rd_data   (rdd8),
    .rd_valid  (rdv8),
    .rd_ready  (rr8),
    .overflow  (ovf8),
    .clr_ovf   (co8),
    .busy      (busy8)
  );

  sensor_link #(.CLK_DIV(CLK_DIV), .NCH(2), .WORD_BITS(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .gate_mode (gate_mode),
    .cmd_data  (cmd_word),
    .cmd_valid (v16),
    .cmd_ready (ready16),
    .cmd_out   (out16),
    .sclk_out  (sclk16),
    .data_in   (data_in),
    .rd_data   (rdd16),
    .rd_valid  (rdv16),
    .rd_ready  (rr16),
    .overflow  (ovf16),
    .clr_ovf   (co16),
    .busy      (busy16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and plays the sensor: returns ret MSB-first, one bit
  // per counted sclk rise, and collects cmd_out on every counted rise.
  // pulse: 0 none, 1 rd_ready, 2 clr_ovf, asserted only for the final rise edge.
  task automatic run_cmd(input string tag, input int nbits, input logic [31:0] word,
                         input logic [15:0] ret, input bit keep, input int pulse,
                         input int abort_at, input logic [7:0] exp_rd, input bit exp_ovf);
    int          nrise;
    int          wait_cnt;
    int          guard;
    int          unstable;
    bit          started;
    bit          pend;
    bit          done;
    logic        prev_sclk;
    logic [1:0]  prev_out;
    logic [31:0] rx0;
    logic [31:0] rx1;
    logic [31:0] mask;
    guard = 0;
    while (!s_ready && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, s_ready, 1'b1);
    cmd_word  = word;
    cmd_valid = 1'b1;
    data_in   = ret[nbits-1];
    tick();
    check({tag, "_busy"}, {s_busy, s_ready}, 2'b10);
    cmd_word = ~word;
    if (!keep) cmd_valid = 1'b0;
    nrise     = 0;
    started   = gate_mode;
    pend      = 1'b0;
    wait_cnt  = 0;
    unstable  = 0;
    rx0       = '0;
    rx1       = '0;
    done      = 1'b0;
    prev_sclk = s_sclk;
    prev_out  = s_cmd_out;
    for (int cyc = 0; cyc < (nbits + 4) * CLK_DIV * 2 && !done; cyc++) begin
      tick();
      if (pend) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          pend = 1'b0;
          if (pulse == 1) rd_ready = 1'b1;
          if (pulse == 2) clr_ovf = 1'b1;
        end
      end
      if (!prev_sclk && s_sclk && started) begin
        nrise++;
        if (s_cmd_out !== prev_out) unstable++;
        rx0 = {rx0[30:0], s_cmd_out[0]};
        rx1 = {rx1[30:0], s_cmd_out[1]};
        if (nrise < nbits) data_in = ret[nbits-1-nrise];
        if (pulse != 0) begin
          rd_ready = 1'b0;
          clr_ovf  = 1'b0;
        end
        if (nrise == nbits) check({tag, "_rd"}, {s_rd_valid, s_rd_data}, {1'b1, exp_rd});
        if (nrise == abort_at) return;
      end
      if (prev_sclk && !s_sclk) begin
        if (started && pulse != 0 && nrise == nbits - 1) begin
          wait_cnt = HALF - 1;
          if (wait_cnt == 0) begin
            if (pulse == 1) rd_ready = 1'b1;
            if (pulse == 2) clr_ovf = 1'b1;
          end else begin
            pend = 1'b1;
          end
        end
        started = 1'b1;
      end
      if (started && !s_busy) done = 1'b1;
      prev_sclk = s_sclk;
      prev_out  = s_cmd_out;
    end
    mask = (32'h1 << nbits) - 32'h1;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_nrise"}, nrise, nbits);
    check({tag, "_ch0"}, rx0 & mask, word & mask);
    check({tag, "_ch1"}, rx1 & mask, (word >> nbits) & mask);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_idle"}, {s_busy, s_cmd_out}, 3'b000);
    check({tag, "_ovf"}, s_ovf, exp_ovf);
  endtask

  task automatic read_byte(input string tag);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check(tag, s_rd_valid, 1'b0);
  endtask

  initial begin
    int highs;
    rst_n     = 1'b0;
    gate_mode = 1'b0;
    cmd_valid = 1'b0;
    data_in   = 1'b0;
    rd_ready  = 1'b0;
    clr_ovf   = 1'b0;
    use16     = 1'b0;
    cmd_word  = '0;

    tick();
    tick();
    check("rst_outs", {s_cmd_out, s_sclk, s_rd_valid, s_ovf, s_busy, s_ready}, 7'b0);
    check("rst_rd_data", s_rd_data, 8'h00);
    rst_n = 1'b1;
    check("rst_ready_before_edge", s_ready, 1'b0);
    tick();
    check("rst_ready_after_edge", s_ready, 1'b1);

    // Basic word with 0xC3 returned
    run_cmd("basic", 8, 32'h0000_A53C, 16'h00C3, 1'b0, 0, 0, 8'hC3, 1'b0);
    read_byte("basic_read_clears");

    // Back-to-back with cmd_valid held; read accepted on the cycle the 2nd byte lands
    run_cmd("b2b_a", 8, 32'h0000_5AF0, 16'h0096, 1'b1, 0, 0, 8'h96, 1'b0);
    run_cmd("b2b_b", 8, 32'h0000_0FC3, 16'h0069, 1'b0, 1, 0, 8'h69, 1'b0);
    read_byte("b2b_read_clears");

    // Gated clock: quiet while idle, exactly one burst per command
    gate_mode = 1'b1;
    tick();
    tick();
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_sclk) highs++;
    end
    check("gate_idle_quiet", highs, 0);
    run_cmd("gated", 8, 32'h0000_3CA5, 16'h005A, 1'b0, 0, 0, 8'h5A, 1'b0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_sclk) highs++;
    end
    check("gate_after_quiet", highs, 0);
    gate_mode = 1'b0;

    // Reset in the middle of a shift, with an unread byte pending
    run_cmd("abort", 8, 32'h0000_F00F, 16'h00FF, 1'b0, 0, 3, 8'h00, 1'b0);
    check("abort_pre_reset", {s_cmd_out, s_sclk, s_rd_valid}, 4'b1011);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {s_cmd_out, s_sclk, s_rd_valid, s_busy, s_ready}, 6'b0);
    check("abort_rd_data", s_rd_data, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    check("abort_ready_before_edge", s_ready, 1'b0);
    tick();
    check("abort_ready_after_edge", s_ready, 1'b1);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rd_valid) highs++;
    end
    check("abort_no_rd_valid", highs, 0);
    run_cmd("fresh", 8, 32'h0000_8001, 16'h0081, 1'b0, 0, 0, 8'h81, 1'b0);
    read_byte("fresh_read_clears");

    // 16-bit words: second byte of a command dropped, then clear races a drop
    use16 = 1'b1;
    tick();
    run_cmd("w16a", 16, 32'hBEEF_4321, 16'h1234, 1'b0, 0, 0, 8'h12, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("w16_clr_ovf", s_ovf, 1'b0);
    check("w16_rd_kept", {s_rd_valid, s_rd_data}, {1'b1, 8'h12});
    run_cmd("w16b", 16, 32'h1357_9BDF, 16'h5678, 1'b0, 2, 0, 8'h12, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
